// File: rtl/psum_requant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_requant_pkg
// Brief    : Shared lane widths, int8 limits and requant FSM state encoding.
// Revision : 1.0
// ============================================================================
package psum_requant_pkg;

    localparam int LANE_W = 32;
    localparam int Q_W    = 8;
    localparam int Q_MAX  = 127;
    localparam int Q_MIN  = -128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BIAS  = 2'd1,
        QUANT = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/psum_requant_if.sv
`default_nettype none
// ============================================================================
// Module   : psum_requant_if
// Brief    : Valid/ready byte-vector channel toward the output buffer.
// Revision : 1.0
// ============================================================================
interface psum_requant_if #(
    parameter int LANES = 9
);
    logic               out_valid;
    logic               out_ready;
    logic [LANES*8-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface
`default_nettype wire

// File: rtl/psum_requant_lane.sv
`default_nettype none
// ============================================================================
// Module   : requant_lane
// Brief    : Per-lane ReLU, round-half-up arithmetic shift and int8 saturation.
// Revision : 1.0
// ============================================================================
module requant_lane
    import psum_requant_pkg::*;
(
    input  wire logic signed [LANE_W:0] s1,
    input  wire logic                   relu_en,
    input  wire logic [4:0]             shift,
    output logic [Q_W-1:0]              q
);

    localparam logic signed [LANE_W+1:0] C_MAX = (LANE_W+2)'(Q_MAX);
    localparam logic signed [LANE_W+1:0] C_MIN = (LANE_W+2)'(Q_MIN);

    logic signed [LANE_W:0]   w_r;
    logic signed [LANE_W+1:0] w_r_ext;
    logic signed [LANE_W+1:0] w_rnd;
    logic signed [LANE_W+1:0] w_sum;
    logic signed [LANE_W+1:0] w_shifted;

    always_comb begin
        w_r       = (relu_en && s1[LANE_W]) ? '0 : s1;
        w_r_ext   = {w_r[LANE_W], w_r};
        // The extra headroom bit keeps the rounding add from wrapping at +max.
        w_rnd     = (LANE_W+2)'(1) << (shift - 5'd1);
        w_sum     = w_r_ext + w_rnd;
        w_shifted = (shift == 5'd0) ? w_r_ext : (w_sum >>> shift);

        if (w_shifted > C_MAX) begin
            q = C_MAX[Q_W-1:0];
        end else if (w_shifted < C_MIN) begin
            q = C_MIN[Q_W-1:0];
        end else begin
            q = w_shifted[Q_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_requant.sv
`default_nettype none
// ============================================================================
// Module   : psum_requant
// Brief    : Counts accumulator passes, captures final lane sums, adds bias,
//            requantises to int8 and hands bytes out over valid/ready.
// Revision : 1.0
// ============================================================================
module psum_requant
    import psum_requant_pkg::*;
#(
    parameter int DW    = 288,
    parameter int LANES = 9,
    parameter int CW    = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    acc_en,
    input  wire logic [DW-1:0]           psum,
    input  wire logic [LANES*LANE_W-1:0] bias,
    input  wire logic [CW-1:0]           num_pass,
    input  wire logic [4:0]              shift,
    input  wire logic                    relu_en,
    output logic                         busy,
    output logic                         overrun,
    psum_requant_if.master               out_if
);

    state_t                          state;
    state_t                          state_next;
    logic [CW-1:0]                   cnt;
    logic                            cap_pend;
    logic [LANES-1:0][LANE_W:0]      s1;
    logic [LANES*Q_W-1:0]            out_data_r;
    logic [LANES*Q_W-1:0]            w_q;
    logic [CW-1:0]                   w_np_eff;
    logic                            w_last;

    assign w_np_eff = (num_pass == '0) ? CW'(1) : num_pass;
    assign w_last   = (cnt == (w_np_eff - CW'(1)));

    // Pass counter is free-running relative to the FSM so the next tile can
    // accumulate while the current one is still being requantised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            cap_pend <= 1'b0;
        end else begin
            cap_pend <= acc_en && w_last;
            if (acc_en) begin
                cnt <= w_last ? '0 : cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cap_pend) state_next = BIAS;
            BIAS:    state_next = QUANT;
            QUANT:   state_next = OUT;
            OUT:     if (out_if.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            out_data_r <= '0;
            overrun    <= 1'b0;
        end else begin
            if (cap_pend && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if ((state == IDLE) && cap_pend) begin
                for (int i = 0; i < LANES; i++) begin
                    s1[i] <= {psum[i*LANE_W+LANE_W-1], psum[i*LANE_W +: LANE_W]}
                           + {bias[i*LANE_W+LANE_W-1], bias[i*LANE_W +: LANE_W]};
                end
            end
            if (state == BIAS) begin
                out_data_r <= w_q;
            end
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            requant_lane u_lane (
                .s1      (s1[g]),
                .relu_en (relu_en),
                .shift   (shift),
                .q       (w_q[g*Q_W +: Q_W])
            );
        end
    endgenerate

    assign out_if.out_valid = (state == OUT);
    assign out_if.out_data  = out_data_r;
    assign busy             = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/psum_requant.md
# psum_requant

Downstream consumer of the lane-parallel partial-sum accumulator. Counts the accumulator's enable pulses per output tile and captures the final 32-bit lane sums once a tile's input-channel passes are complete. Adds a per-lane bias, applies optional ReLU and a rounding arithmetic right shift, then saturates each lane to int8. Hands the packed byte vector to the output buffer over a valid/ready interface.

## Interface
- `DW`, 288: partial-sum bus width. Must equal LANES*32.
- `LANES`, 9: number of 32-bit lanes.
- `CW`, 8: pass-counter width.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `acc_en` in 1: same pulse that drives the accumulator's enable; one pulse = one pass.
- `psum` in DW: accumulator output. Lane i = bits [i*32+:32], signed two's complement.
- `bias` in LANES*32: per-lane signed bias. Must be stable from the final pass until `out_valid`.
- `num_pass` in CW: passes per tile. 0 is treated as 1. Must be stable while the pass count is nonzero.
- `shift` in 5: requant right-shift amount, 0..31.
- `relu_en` in 1: clamp negative results to 0.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts.
- `out_data` out LANES*8: lane i = bits [i*8+:8], signed int8.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky; a tile completed while the previous tile was still in flight.

## Operation
- Pass counter `cnt` (CW bits), reset 0.
  - On `acc_en`: if `cnt == max(num_pass,1)-1`, set `cnt` to 0 and set `cap_pend` for one cycle; otherwise increment `cnt`.
- `cap_pend` is registered, so it is high in the cycle after the final `acc_en`. In that cycle `psum` already holds the final sum.
- FSM states: IDLE, BIAS, QUANT, OUT.
  - IDLE to BIAS on `cap_pend`. Register `s1[i] = sext33(psum[i]) + sext33(bias[i])`, 33-bit signed with no wrap.
  - BIAS to QUANT unconditionally.
    - `r = relu_en && s1<0 ? 0 : s1`.
    - If `shift == 0`: `q = r`.
    - Otherwise: `q = (r + (1<<(shift-1))) >>> shift`, computed at 34 bits (round half toward +inf).
    - Saturate `q` to [-128,127] and register into `out_data`.
  - QUANT to OUT unconditionally, with `out_valid = 1`.
  - OUT to IDLE on `out_ready`. `out_data` is held unchanged until accepted.
- If `cap_pend` is high while the FSM is not IDLE: that tile is dropped and `overrun` is set. This applies even in OUT with `out_ready` high in the same cycle. `overrun` clears only on reset.
- The pass counter runs independently of the FSM. Accumulation of the next tile may overlap requant of the current one.
- Reset mid-operation: all state returns to reset values immediately. A partially counted tile is lost.
- Reset values: `out_valid = 0`, `out_data = 0`, `busy = 0`, `overrun = 0`, `cnt = 0`, FSM = IDLE.

## Timing
- Final `acc_en` sampled at edge E. `cap_pend` is high during E to E+1. BIAS captures at E+1. QUANT at E+2. `out_valid` rises after E+3.
- Latency is 3 cycles from the final-pass edge to `out_valid`.
- Throughput: one tile per 4 cycles with `out_ready` held high. Tiles with `num_pass >= 4` never overrun when the consumer is always ready.
- `out_valid` never drops without a handshake. `out_data` is stable while `out_valid && !out_ready`.
- No combinational path from `out_ready` to `out_valid` or `out_data`.

## Structure
- Shared accelerator package holds:
  - `LANE_W = 32`, `Q_W = 8`, `Q_MAX = 127`, `Q_MIN = -128`;
  - the state enum {IDLE, BIAS, QUANT, OUT}.
- One sub-module, `requant_lane`: combinational ReLU, rounding shift and saturation for a single lane. It is instantiated LANES times under a generate loop.
- Counter, FSM and registers stay in the top module.

## Test plan
- `num_pass = 3`, three `acc_en` pulses, `psum` lane0 = 1000, `bias` 24, `shift` 3, `relu_en` 0 -> 3 cycles later `out_valid`, lane0 = 127. (1024>>3 = 128 saturates.)
- lane0 `psum` = -300, `bias` 0, `shift` 2 -> lane0 = -75 with `relu_en` 0; the same input with `relu_en` 1 gives 0. Rounding check: `psum` = 6, `shift` 2 -> 2; `psum` = -6, `shift` 2 -> -1.
- `psum` = 0x7FFFFFFF, `bias` = 0x7FFFFFFF, `shift` 31 -> 33-bit sum gives 2, with no wraparound.
- Hold `out_ready` = 0 for 10 cycles -> `out_valid` and `out_data` stable. Then `out_ready` = 1 for one cycle -> `out_valid` = 0 next cycle, `busy` = 0.
- `num_pass = 1`, `acc_en` on two consecutive cycles -> second tile dropped, `overrun` = 1 and stays 1. The first tile's result is delivered intact.
- Assert `rst_n` = 0 during QUANT and release it -> all outputs 0. The next 2-pass tile (`num_pass = 2`) completes normally.
